bus_grant_arbiter: RTL and testbench
====================================

# bus_grant_arbiter

Upstream stage of the bus-source encoder in the datapath. It collects "drive the bus" requests from the 16 general registers and the 8 special sources (HI, LO, Zhigh, Zlow, PC, MDR, InPort, C), then grants exactly one source at a time using round-robin order. The grant is a one-hot 32-bit vector in the encoder's input layout, so the encoder always sees a legal single-hot code and never its hold-on-default case. The block also guarantees an idle gap between grants and reports completion of each transfer.

## Interface
Parameters:
- GRANT_CYCLES, default 1: number of cycles each grant is held (1..15), not counting stall extension.
- GAP_EN, default 1: when 1, one dead cycle with all grants low is inserted after every grant.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clear  input  1  reset, asynchronous, active-high.
- req  input  24  request pulses or levels, sampled every edge. Bits 0-15 map to R0-R15; 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C.
- stall  input  1  while high during GRANT, the current grant is held and the hold counter is frozen.
- grant_i  output  32  one-hot grant in encoder layout. Bits 23:0 follow req numbering; bits 31:24 are always 0.
- grant_reg  output  16  copy of grant_i[15:0].
- grant_id  output  5  binary index of the granted source; 0 when idle.
- busy  output  1  high in GRANT and GAP.
- done  output  1  one-cycle pulse on the cycle after a grant ends.
- pending  output  24  latched outstanding requests.

## Operation
- Reset (clear high, async): pending=0, grant_i=0, grant_reg=0, grant_id=0, busy=0, done=0, state=IDLE, hold counter=0, round-robin pointer=23 (so R0 is searched first).
- Pending update each edge: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of the grant ending this edge.
  - Set wins over clear, so a re-request from the source being released stays pending.
- State machine:
  - IDLE: if pending != 0, search from (pointer+1) mod 24 upward with wrap-around and pick the first set bit. Load grant_i one-hot, grant_id = index, pointer = index, counter = GRANT_CYCLES-1, then go to GRANT. Otherwise stay in IDLE with all grant outputs at 0.
  - GRANT: if stall=1, hold everything. Else if counter != 0, decrement. Else (counter == 0, stall=0): clear grant_i/grant_reg/grant_id, clear that pending bit, pulse done, and go to GAP if GAP_EN=1, otherwise IDLE.
  - GAP: go to IDLE; all grants stay 0.
- The arbitration search only considers pending as registered; req arriving in the same edge is not eligible until the next IDLE evaluation.
- grant_i, grant_reg and grant_id are registered and mutually consistent in every cycle. grant_i has at most one bit set at all times.
- Out-of-range search cannot occur: indices 24-31 are never granted.

## Timing
- req sampled at edge k → pending visible after k. If IDLE, grant asserts after edge k+1, so minimum request-to-grant latency is 2 edges.
- Grant width = GRANT_CYCLES cycles plus one extra cycle for each stalled GRANT cycle.
- done is high for exactly the one cycle after grant_i drops to 0.
- Throughput, GAP_EN=1: one grant per GRANT_CYCLES+2 cycles (grant, gap, IDLE decision). With GAP_EN=0: GRANT_CYCLES+1.
- The downstream encoder registers its output, so its select code is valid one cycle after grant_i.
- clear asserted mid-grant drops grant_i to 0 immediately (asynchronously) and discards all pending requests. Operation resumes at the first edge after clear falls.

## Test plan
- Reset: assert clear with req=0xFFFFFF → all outputs 0. Release → grant_i=0x1 (R0) two edges later, busy=1.
- Single request, default parameters: pulse req[5] one cycle → grant_i=0x20, grant_reg=0x20, grant_id=5 for 1 cycle → done=1 → one gap cycle → IDLE, pending=0.
- Simultaneous requests: req[3] and req[20] (PC) in the same cycle, pointer at 23 → R3 granted first (grant_i=0x8), then PC (grant_i=0x100000, grant_id=20). Never two bits set.
- Wrap-around: grant C (bit 23, grant_i=0x800000), with pending R0 and R22 → next grant is R0, then R22.
- Stall and hold: GRANT_CYCLES=3 with stall high for 2 cycles mid-grant → grant width is 5 cycles. Re-requesting the same bit on the final grant edge → that source is granted again after the gap.
- Reset mid-operation: clear asserted during the second cycle of a 3-cycle MDR grant (bit 21) with R7 pending → grant_i=0 at once, pending=0, no done pulse, no grant after release until a new req.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter that picks one of 24 bus sources and drives a one-hot grant for the bus encoder.
// Latency: a request sampled at edge k is granted after edge k+1; each grant lasts GRANT_CYCLES plus stalled cycles.
// Backpressure: stall freezes the active grant and its hold counter; requests keep accumulating in pending meanwhile.
//
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-high reset; drops all grants and pending requests at once
//   req        24 request bits: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C
//   stall      holds the current grant while high in GRANT
//   grant_i    one-hot grant in encoder layout; bits 31:24 are always 0
//   grant_reg  copy of grant_i[15:0]
//   grant_id   binary index of the granted source, 0 when idle
//   busy       high in GRANT and GAP
//   done       one-cycle pulse in the cycle after a grant ends
//   pending    latched outstanding requests
module bus_grant_arbiter #(
    parameter int GRANT_CYCLES = 1,
    parameter int GAP_EN       = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [23:0] req,
    input  logic        stall,
    output logic [31:0] grant_i,
    output logic [15:0] grant_reg,
    output logic [4:0]  grant_id,
    output logic        busy,
    output logic        done,
    output logic [23:0] pending
);

    localparam int         NSRC      = 24;
    localparam logic [3:0] HOLD_INIT = 4'(GRANT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  ptr, ptr_nxt;          // index of the most recently granted source
    logic [3:0]  cnt, cnt_nxt;          // remaining hold cycles after the current one
    logic [23:0] gnt_q, gnt_nxt;
    logic [4:0]  id_q, id_nxt;
    logic        done_q, done_nxt;
    logic [23:0] pend_q, pend_nxt;
    logic [23:0] clr_mask;
    logic [5:0]  pick;                  // {found, index}

    // Search starting just after the last winner, wrapping at 24. The loop runs
    // from the farthest candidate to the nearest so the nearest set bit is the
    // last one written, which gives first-hit priority without a break.
    function automatic logic [5:0] rr_search(input logic [23:0] vec, input logic [4:0] last);
        logic [5:0] res;
        int         cand;
        res = 6'd0;
        for (int off = NSRC - 1; off >= 0; off--) begin
            cand = (int'(last) + 1 + off) % NSRC;
            if (vec[cand]) begin
                res = {1'b1, 5'(cand)};
            end
        end
        return res;
    endfunction

    // Only the registered pending vector is searched; a request arriving on
    // the same edge waits for the next IDLE evaluation.
    always_comb begin
        pick = rr_search(pend_q, ptr);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        done_nxt  = 1'b0;
        clr_mask  = 24'd0;

        case (state)
            IDLE: begin
                if (pick[5]) begin
                    gnt_nxt   = 24'd1 << pick[4:0];
                    id_nxt    = pick[4:0];
                    ptr_nxt   = pick[4:0];
                    cnt_nxt   = HOLD_INIT;
                    state_nxt = GRANT;
                end else begin
                    gnt_nxt = 24'd0;
                    id_nxt  = 5'd0;
                end
            end
            GRANT: begin
                if (!stall) begin
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        clr_mask  = gnt_q;
                        gnt_nxt   = 24'd0;
                        id_nxt    = 5'd0;
                        done_nxt  = 1'b1;
                        state_nxt = (GAP_EN != 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                gnt_nxt   = 24'd0;
                id_nxt    = 5'd0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = 24'd0;
                id_nxt    = 5'd0;
                state_nxt = IDLE;
            end
        endcase

        // New requests are OR-ed in after the release mask, so a source that
        // re-requests on its own final grant edge stays pending.
        pend_nxt = (pend_q & ~clr_mask) | req;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            ptr    <= 5'd23;    // R0 is searched first after reset
            cnt    <= 4'd0;
            gnt_q  <= 24'd0;
            id_q   <= 5'd0;
            done_q <= 1'b0;
            pend_q <= 24'd0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            gnt_q  <= gnt_nxt;
            id_q   <= id_nxt;
            done_q <= done_nxt;
            pend_q <= pend_nxt;
        end
    end

    assign grant_i   = {8'h00, gnt_q};
    assign grant_reg = gnt_q[15:0];
    assign grant_id  = id_q;
    assign busy      = (state == GRANT) || (state == GAP);
    assign done      = done_q;
    assign pending   = pend_q;

    a_onehot : assert property (@(posedge clk) disable iff (clear) $onehot0(grant_i));
    a_id_range : assert property (@(posedge clk) disable iff (clear) grant_id < 5'd24);

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Bench for bus_grant_arbiter: three instances (defaults; 3-cycle hold; 4-cycle hold without gap)
// share clock and clear; expected grants (instance, id, width) go into a scoreboard queue when
// stimulus is driven and a negedge monitor pops and checks them as grants appear.
module tb_bus_grant_arbiter;

    logic clk;
    logic clear;
    logic [2:0][23:0] req;
    logic [2:0]       stall;

    wire [2:0][31:0] gi;
    wire [2:0][15:0] greg;
    wire [2:0][4:0]  gid;
    wire [2:0]       busy;
    wire [2:0]       done;
    wire [2:0][23:0] pend;

    bus_grant_arbiter #(.GRANT_CYCLES(1), .GAP_EN(1)) dut_a (
        .clk(clk), .clear(clear), .req(req[0]), .stall(stall[0]),
        .grant_i(gi[0]), .grant_reg(greg[0]), .grant_id(gid[0]),
        .busy(busy[0]), .done(done[0]), .pending(pend[0])
    );

    bus_grant_arbiter #(.GRANT_CYCLES(3), .GAP_EN(1)) dut_b (
        .clk(clk), .clear(clear), .req(req[1]), .stall(stall[1]),
        .grant_i(gi[1]), .grant_reg(greg[1]), .grant_id(gid[1]),
        .busy(busy[1]), .done(done[1]), .pending(pend[1])
    );

    bus_grant_arbiter #(.GRANT_CYCLES(4), .GAP_EN(0)) dut_c (
        .clk(clk), .clear(clear), .req(req[2]), .stall(stall[2]),
        .grant_i(gi[2]), .grant_reg(greg[2]), .grant_id(gid[2]),
        .busy(busy[2]), .done(done[2]), .pending(pend[2])
    );

    // width 0 marks a grant that clear is expected to cut short
    typedef struct {
        int         inst;
        logic [4:0] id;
        int         width;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   active[3];
    exp_t cur[3];
    int   width_cnt[3];
    int   last_start[3];
    int   prev_start[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [4:0] id, input int width);
        exp_t e;
        e.inst  = inst;
        e.id    = id;
        e.width = width;
        sb.push_back(e);
    endtask

    task automatic drain(input int idx);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && !busy[idx] && !active[idx]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("drain", {31'd0, ok}, 32'd1);
    endtask

    // Monitor: grant start pops the scoreboard, grant end checks the width,
    // done must be high exactly in the cycle after a grant ends.
    initial begin
        for (int i = 0; i < 3; i++) begin
            active[i]     = 1'b0;
            width_cnt[i]  = 0;
            last_start[i] = 0;
            prev_start[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    if (active[i]) chk("abort_expected", cur[i].width, 0);
                    active[i] = 1'b0;
                end else begin
                    chk("done", {31'd0, done[i]}, {31'd0, (active[i] && gi[i] == 32'd0)});
                    if (gi[i] != 32'd0) begin
                        chk("gi_vs_id", gi[i], 32'd1 << gid[i]);
                        chk("grant_reg", {16'd0, greg[i]}, {16'd0, gi[i][15:0]});
                        if (!active[i]) begin
                            if (sb.size() == 0) begin
                                chk("unexpected_grant", {27'd0, gid[i]}, 32'hFFFF_FFFF);
                                cur[i].inst  = i;
                                cur[i].id    = gid[i];
                                cur[i].width = -1;
                            end else begin
                                cur[i] = sb.pop_front();
                                chk("grant_inst", i, cur[i].inst);
                                chk("grant_id", {27'd0, gid[i]}, {27'd0, cur[i].id});
                            end
                            width_cnt[i]  = 0;
                            active[i]     = 1'b1;
                            prev_start[i] = last_start[i];
                            last_start[i] = cyc;
                        end
                        width_cnt[i]++;
                    end else if (active[i]) begin
                        chk("grant_width", width_cnt[i], cur[i].width);
                        active[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        stall = 3'b000;
        req   = '0;
        req[0] = 24'hFF_FFFF;
        repeat (3) @(posedge clk);
        #1;

        // Reset with every request asserted
        chk("rst_grant_i", gi[0], 32'd0);
        chk("rst_grant_reg", {16'd0, greg[0]}, 32'd0);
        chk("rst_grant_id", {27'd0, gid[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_done", {31'd0, done[0]}, 32'd0);
        chk("rst_pending", {8'd0, pend[0]}, 32'd0);

        // Release: all 24 sources latched, served in order R0..C
        clear = 1'b0;
        for (int i = 0; i < 24; i++) push(0, 5'(i), 1);
        step();
        req[0] = 24'd0;
        chk("rel_pending", {8'd0, pend[0]}, 32'h00FF_FFFF);
        chk("rel_no_grant_yet", gi[0], 32'd0);
        step();
        chk("rel_first_grant", gi[0], 32'h0000_0001);
        chk("rel_busy", {31'd0, busy[0]}, 32'd1);
        drain(0);
        chk("rel_pending_empty", {8'd0, pend[0]}, 32'd0);

        // Simultaneous R3 and PC with pointer at 23
        push(0, 5'd3, 1);
        push(0, 5'd20, 1);
        req[0] = 24'h10_0008;
        step();
        req[0] = 24'd0;
        drain(0);
        chk("gap_throughput", last_start[0] - prev_start[0], 3);

        // Wrap-around: C, then R0, then R22
        push(0, 5'd23, 1);
        push(0, 5'd0, 1);
        push(0, 5'd22, 1);
        req[0] = 24'h80_0000;
        step();
        req[0] = 24'd0;
        step();
        chk("wrap_c_grant", gi[0], 32'h0080_0000);
        req[0] = 24'h40_0001;
        step();
        req[0] = 24'd0;
        chk("wrap_pending", {8'd0, pend[0]}, 32'h0040_0001);
        drain(0);

        // Single one-cycle pulse on R5
        push(0, 5'd5, 1);
        req[0] = 24'h00_0020;
        step();
        req[0] = 24'd0;
        chk("single_pending", {8'd0, pend[0]}, 32'h0000_0020);
        chk("single_idle", gi[0], 32'd0);
        step();
        chk("single_grant_i", gi[0], 32'h0000_0020);
        chk("single_grant_reg", {16'd0, greg[0]}, 32'h0000_0020);
        chk("single_grant_id", {27'd0, gid[0]}, 32'd5);
        step();
        chk("single_done", {31'd0, done[0]}, 32'd1);
        chk("single_gap_busy", {31'd0, busy[0]}, 32'd1);
        chk("single_gap_grant", gi[0], 32'd0);
        chk("single_pending_clr", {8'd0, pend[0]}, 32'd0);
        step();
        chk("single_idle_busy", {31'd0, busy[0]}, 32'd0);
        chk("single_idle_done", {31'd0, done[0]}, 32'd0);
        drain(0);

        // No gap: R1 and R2 back to back, 4-cycle holds
        push(2, 5'd1, 4);
        push(2, 5'd2, 4);
        req[2] = 24'h00_0006;
        step();
        req[2] = 24'd0;
        drain(2);
        chk("nogap_throughput", last_start[2] - prev_start[2], 5);

        // Stall two cycles in a 3-cycle grant; re-request on the final edge
        push(1, 5'd9, 5);
        push(1, 5'd9, 3);
        req[1] = 24'h00_0200;
        step();
        req[1] = 24'd0;
        step();
        stall[1] = 1'b1;
        step();
        step();
        stall[1] = 1'b0;
        step();
        step();
        req[1] = 24'h00_0200;
        step();
        req[1] = 24'd0;
        chk("stall_rereq_pending", {8'd0, pend[1]}, 32'h0000_0200);
        chk("stall_end_grant", gi[1], 32'd0);
        chk("stall_end_done", {31'd0, done[1]}, 32'd1);
        drain(1);

        // clear in the second cycle of a 3-cycle MDR grant with R7 pending
        push(1, 5'd21, 0);
        req[1] = 24'h20_0000;
        step();
        req[1] = 24'h00_0080;
        step();
        req[1] = 24'd0;
        chk("mdr_grant", gi[1], 32'h0020_0000);
        step();
        chk("mdr_pending", {8'd0, pend[1]}, 32'h0020_0080);
        clear = 1'b1;
        #1;
        chk("clr_grant_i", gi[1], 32'd0);
        chk("clr_grant_reg", {16'd0, greg[1]}, 32'd0);
        chk("clr_grant_id", {27'd0, gid[1]}, 32'd0);
        chk("clr_pending", {8'd0, pend[1]}, 32'd0);
        chk("clr_done", {31'd0, done[1]}, 32'd0);
        chk("clr_busy", {31'd0, busy[1]}, 32'd0);
        step();
        step();
        clear = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("post_clr_grant", gi[1], 32'd0);
            chk("post_clr_done", {31'd0, done[1]}, 32'd0);
        end
        chk("post_clr_pending", {8'd0, pend[1]}, 32'd0);

        // Fresh request after clear: pointer back at 23
        push(1, 5'd2, 3);
        req[1] = 24'h00_0004;
        step();
        req[1] = 24'd0;
        drain(1);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
